// File: rtl/commit_trace_buf.sv
// Commit trace buffer: captures each retired instruction into a show-ahead FIFO
// drained by the simulation harness, and requests finish once a halt condition is met.
module commit_trace_buf #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned MAX_INSTR   = 200,
    parameter bit          HALT_ON_SYS = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        retire_valid,
    input  logic [31:0] retire_pc,
    input  logic [31:0] retire_instr,
    input  logic [4:0]  retire_rd,
    input  logic        retire_rd_we,
    input  logic [31:0] retire_rd_val,
    output logic        trc_valid,
    input  logic        trc_ready,
    output logic [31:0] trc_pc,
    output logic [31:0] trc_instr,
    output logic [4:0]  trc_rd,
    output logic        trc_rd_we,
    output logic [31:0] trc_rd_val,
    output logic [31:0] instr_count,
    output logic        overflow,
    output logic [15:0] drop_count,
    output logic        halted,
    output logic        finish_req
);
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
    localparam logic [31:0] ECALL   = 32'h0000_0073;
    localparam logic [31:0] EBREAK  = 32'h0010_0073;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        rd_we;
        logic [31:0] rd_val;
    } rec_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALTING,
        ST_HALTED
    } state_e;

    rec_t        mem_q [DEPTH];
    rec_t        rec_in;
    rec_t        head;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [31:0] instr_count_q, instr_count_d;
    logic [15:0] drop_count_q, drop_count_d;
    logic        overflow_q, overflow_d;
    state_e      state_q, state_d;

    logic        empty, full, pop, accept, push, drop;
    logic        sys_hit, limit_hit;
    logic [31:0] count_inc;
    logic [15:0] drop_inc;

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop    = !empty && trc_ready;
    assign accept = (state_q == ST_RUN) && retire_valid;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push   = accept && (!full || pop);
    assign drop   = accept && full && !pop;

    assign count_inc = (instr_count_q == '1) ? instr_count_q : instr_count_q + 32'd1;
    assign drop_inc  = (drop_count_q == '1) ? drop_count_q : drop_count_q + 16'd1;
    assign sys_hit   = HALT_ON_SYS && ((retire_instr == ECALL) || (retire_instr == EBREAK));
    assign limit_hit = (MAX_INSTR != 0) && (count_inc == 32'(MAX_INSTR));

    always_comb begin
        rec_in.pc     = retire_pc;
        rec_in.instr  = retire_instr;
        rec_in.rd     = retire_rd;
        rec_in.rd_we  = 1'b0;
        rec_in.rd_val = 32'd0;
        if (retire_rd_we && (retire_rd != 5'd0)) begin
            rec_in.rd_we  = 1'b1;
            rec_in.rd_val = retire_rd_val;
        end
    end

    always_comb begin
        wr_ptr_d      = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d      = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        instr_count_d = accept ? count_inc : instr_count_q;
        drop_count_d  = drop ? drop_inc : drop_count_q;
        overflow_d    = overflow_q | drop;
        state_d       = state_q;
        case (state_q)
            ST_RUN:     if (accept && (limit_hit || sys_hit)) state_d = ST_HALTING;
            // Uses post-pop occupancy so the last pop moves straight to HALTED.
            ST_HALTING: if (wr_ptr_d == rd_ptr_d) state_d = ST_HALTED;
            ST_HALTED:  state_d = ST_HALTED;
            default:    state_d = ST_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            instr_count_q <= '0;
            drop_count_q  <= '0;
            overflow_q    <= 1'b0;
            state_q       <= ST_RUN;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            instr_count_q <= instr_count_d;
            drop_count_q  <= drop_count_d;
            overflow_q    <= overflow_d;
            state_q       <= state_d;
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only visible
    // after it has been written, so resetting the pointers is enough.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= rec_in;
    end

    assign head        = mem_q[rd_ptr_q[AW-1:0]];
    assign trc_valid   = !empty;
    assign trc_pc      = head.pc;
    assign trc_instr   = head.instr;
    assign trc_rd      = head.rd;
    assign trc_rd_we   = head.rd_we;
    assign trc_rd_val  = head.rd_val;
    assign instr_count = instr_count_q;
    assign overflow    = overflow_q;
    assign drop_count  = drop_count_q;
    assign halted      = (state_q != ST_RUN);
    assign finish_req  = (state_q == ST_HALTED);
endmodule
